// File: rtl/ctrl_defs.sv
// Shared state codes for the control sequencer and the output decoder.
// Holds state width, state enum, and small state-class helpers.
package ctrl_defs;

  localparam int ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 4'b0000,
    ST_B1     = 4'b0001,
    ST_B2     = 4'b0010,
    ST_B3     = 4'b0011,
    ST_B4     = 4'b0100,
    ST_B5     = 4'b0101,
    ST_B6     = 4'b0110,
    ST_B7     = 4'b0111,
    ST_B8     = 4'b1000,
    ST_B9     = 4'b1001,
    ST_B10    = 4'b1010,
    ST_DONE   = 4'b1011,
    ST_LOOP_A = 4'b1110,
    ST_LOOP_B = 4'b1111
  } state_e;

  localparam logic [ST_W-1:0] ST_BAD0 = 4'b1100;
  localparam logic [ST_W-1:0] ST_BAD1 = 4'b1101;

  function automatic logic is_illegal(
    input logic [ST_W-1:0] s
  );
    return (s == ST_BAD0) || (s == ST_BAD1);
  endfunction

  function automatic logic is_busy(
    input logic [ST_W-1:0] s
  );
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/iter_counter.sv
// Loop pass counter: load, decrement, hold, zero flag.
// Ports: clk, rst, i_load/i_ld_val, i_dec, i_hold -> o_cnt, o_zero.
module iter_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_ld_val,
  input  logic         i_dec,
  input  logic         i_hold,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_hold) begin
      r_cnt <= r_cnt;
    end else if (i_load) begin
      r_cnt <= i_ld_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/control_sequencer.sv
// Next-state engine: 4-bit state S, body/loop sequencing, start/ack.
// Ports: clk, rst, start, n_iter, hold, ack, [step] -> S, busy,
// iter_left, err. Option macro: CTRL_SINGLE_STEP_EN adds `step`.
module control_sequencer
  import ctrl_defs::*;
#(
  parameter int ITER_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ITER_W-1:0] n_iter,
  input  logic              hold,
  input  logic              ack,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [ST_W-1:0]   S,
  output logic              busy,
  output logic [ITER_W-1:0] iter_left,
  output logic              err
);

  logic [ST_W-1:0] r_s;
  logic            r_err;
  logic            w_adv;
  logic            w_bad;
  logic            w_zero;
  logic            w_load;
  logic            w_dec;
  logic            w_cnt_hold;

`ifdef CTRL_SINGLE_STEP_EN
  assign w_adv = !hold && step;
`else
  assign w_adv = !hold;
`endif

  assign w_bad = is_illegal(r_s);

  // counter only moves on the two transitions that own it
  assign w_load = (r_s == ST_IDLE) && start;
  assign w_dec  = (r_s == ST_B10) && !w_zero;
  assign w_cnt_hold = !w_adv || w_bad;

  iter_counter #(
    .W (ITER_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_ld_val (n_iter),
    .i_dec    (w_dec),
    .i_hold   (w_cnt_hold),
    .o_cnt    (iter_left),
    .o_zero   (w_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s   <= ST_IDLE;
      r_err <= 1'b0;
    end else if (w_bad) begin
      // recovery ignores hold/step
      r_s   <= ST_IDLE;
      r_err <= 1'b1;
    end else if (w_adv) begin
      unique case (r_s)
        ST_IDLE: begin
          if (start) r_s <= ST_B1;
        end
        ST_B1, ST_B2, ST_B3, ST_B4, ST_B5,
        ST_B6, ST_B7, ST_B8, ST_B9: begin
          r_s <= r_s + 1'b1;
        end
        ST_B10: begin
          r_s <= w_zero ? ST_DONE : ST_LOOP_A;
        end
        ST_DONE: begin
          if (ack) r_s <= ST_IDLE;
        end
        ST_LOOP_A: r_s <= ST_LOOP_B;
        ST_LOOP_B: r_s <= ST_B1;
        default:   r_s <= ST_IDLE;
      endcase
    end
  end

  assign S    = r_s;
  assign err  = r_err;
  assign busy = is_busy(r_s);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer.
// Drives after posedge+1, samples before the next edge.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] n_iter;
  logic       hold;
  logic       ack;
`ifdef CTRL_SINGLE_STEP_EN
  logic       step = 1'b1;
`endif
  logic [3:0] S;
  logic       busy;
  logic [3:0] iter_left;
  logic       err;

  int nasrt = 0;
  int nfail = 0;

  control_sequencer #(.ITER_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_iter    (n_iter),
    .hold      (hold),
    .ack       (ack),
`ifdef CTRL_SINGLE_STEP_EN
    .step      (step),
`endif
    .S         (S),
    .busy      (busy),
    .iter_left (iter_left),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ticks until S==tgt or lim ticks; n = ticks taken
  task automatic wait_s(input logic [3:0] tgt, input int lim,
                        output int n);
    n = 0;
    while (S !== tgt && n < lim) begin
      tick();
      n++;
    end
    chk("wait_bound", int'(n < lim), 1);
  endtask

  int n;
  int cyc;
  int bcnt;
  int visits;
  int it0;
  int it1;

  initial begin
    rst = 1'b1; start = 1'b0; n_iter = 4'd0;
    hold = 1'b0; ack = 1'b0;
    tick(); tick();
    chk("rst_S", S, 0);
    chk("rst_iter", iter_left, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // single pass
    start = 1'b1; n_iter = 4'd0;
    tick();
    start = 1'b0;
    chk("p1_t1", S, 1);
    bcnt = int'(busy);
    for (int i = 2; i <= 11; i++) begin
      tick();
      bcnt += int'(busy);
    end
    chk("p1_done_t11", S, 11);
    tick(); tick();
    chk("p1_done_hold", S, 11);
    chk("p1_busy_cnt", bcnt, 10);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("p1_ack_idle", S, 0);

    // two extra passes
    start = 1'b1; n_iter = 4'd2;
    tick();
    start = 1'b0;
    chk("p2_load", iter_left, 2);
    cyc = 1; visits = 0; it0 = -1; it1 = -1;
    while (S !== 4'd11 && cyc < 100) begin
      tick();
      cyc++;
      if (S == 4'he) begin
        if (visits == 0) it0 = iter_left;
        else it1 = iter_left;
        visits++;
      end
    end
    chk("p2_latency", cyc, 35);
    chk("p2_loops", visits, 2);
    chk("p2_iter_a", it0, 1);
    chk("p2_iter_b", it1, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // hold 3 cycles at 0101
    start = 1'b1; n_iter = 4'd0;
    tick();
    start = 1'b0;
    wait_s(4'd5, 20, n);
    chk("h_reach5", n + 1, 5);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("h_frozen", S, 5);
    end
    hold = 1'b0;
    wait_s(4'd11, 40, n);
    chk("h_latency", n + 5 + 3, 14);
    // hold blocks ack in DONE
    hold = 1'b1; ack = 1'b1;
    tick();
    chk("h_ack_blk", S, 11);
    hold = 1'b0;
    tick();
    ack = 1'b0;
    chk("h_ack_ok", S, 0);

    // start ignored mid-run and with ack
    start = 1'b1; n_iter = 4'd0;
    tick();
    start = 1'b0;
    wait_s(4'd4, 20, n);
    start = 1'b1; n_iter = 4'd5;
    tick();
    start = 1'b0;
    chk("s_mid_S", S, 5);
    chk("s_mid_iter", iter_left, 0);
    wait_s(4'd11, 40, n);
    chk("s_mid_lat", n, 6);
    start = 1'b1; ack = 1'b1;
    tick();
    start = 1'b0; ack = 1'b0;
    chk("s_ack_idle", S, 0);
    tick();
    chk("s_no_queue", S, 0);
    start = 1'b1; n_iter = 4'd0;
    tick();
    start = 1'b0;
    chk("s_restart", S, 1);
    wait_s(4'd11, 40, n);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // reset at 1111 with iter_left 1
    start = 1'b1; n_iter = 4'd2;
    tick();
    start = 1'b0;
    wait_s(4'hf, 40, n);
    chk("r_iter1", iter_left, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_S", S, 0);
    chk("r_iter", iter_left, 0);
    chk("r_err", err, 0);
    tick();
    chk("r_stay", S, 0);

    // illegal state recovery, sticky err
    force dut.r_s = 4'hd;
    #1;
    release dut.r_s;
    chk("ill_forced", S, 13);
    tick();
    chk("ill_S", S, 0);
    chk("ill_err", err, 1);
    start = 1'b1; n_iter = 4'd1;
    tick();
    start = 1'b0;
    wait_s(4'd11, 60, n);
    chk("ill_run_lat", n + 1, 23);
    chk("ill_err_run", err, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ill_err_idle", err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ill_err_clr", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nasrt, nfail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Next-state engine of the datapath controller. Holds the 4-bit state register `S` that drives the combinational control-output decoder directly downstream. Sequences one datapath pass through states 0000→1011, optionally repeating the arithmetic body via a loop branch (1110/1111). Provides start/ack handshaking toward the host.

## Interface
- `ITER_W`, default 4: width of the iteration-count input and counter.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset; overrides every other input.
- `start` input 1: begin a run; sampled only in IDLE.
- `n_iter` input ITER_W: extra loop passes; latched with `start`. Total passes = `n_iter`+1.
- `hold` input 1: freeze state and counter while high.
- `ack` input 1: host acknowledges DONE; returns sequencer to IDLE.
- `S` output 4: registered state code feeding the output decoder.
- `busy` output 1: high when `S` is neither 0000 nor 1011.
- `iter_left` output ITER_W: remaining loop passes.
- `err` output 1: sticky illegal-state flag.

## Operation
- State codes:
  - IDLE 0000.
  - Body 0001–1010, linear.
  - DONE 1011.
  - LOOP_A 1110.
  - LOOP_B 1111.
  - 1100 and 1101 are illegal.
- IDLE: on `start`=1 and `hold`=0, latch `n_iter` into `iter_left` and go to 0001. Otherwise stay in IDLE.
- Body: 0001→0010→…→1001→1010, one state per cycle.
- At 1010:
  - `iter_left`≠0: go to 1110 and decrement `iter_left`.
  - `iter_left`=0: go to 1011.
- Loop branch: 1110→1111→0001.
- DONE: stay until `ack`=1, then go to 0000. `start` is ignored in DONE, even when it arrives in the same cycle as `ack`.
- `start` is ignored in every non-IDLE state. It is not queued.
- `hold`=1 freezes `S` and `iter_left` in any state. In IDLE this means `start` is not accepted. In DONE, `ack` is not accepted.
- Illegal state (1100/1101): next state 0000, `err`←1. `err` stays set until `rst`. Recovery is not gated by `hold`.
- Counter arithmetic: unsigned, ITER_W bits. It is decremented only on the 1010→1110 transition, so it never underflows.
- Reset values: `S`=0000, `iter_left`=0, `err`=0, `busy`=0.
- Reset mid-run: the run is abandoned and the sequencer is in IDLE on the next cycle. No DONE is produced.

## Timing
- All outputs are registered, or are pure decodes of registered `S`.
- `start` accepted in cycle t → `S`=0001 at t+1.
- Single pass with no holds: 0001 at t+1, 1010 at t+10, 1011 at t+11.
- Each extra pass adds 12 cycles (1110, 1111, then 0001–1010).
- Run latency from start to DONE = 11 + 12·`n_iter` cycles, plus any hold cycles.
- `ack` in cycle t while in DONE → `S`=0000 at t+1. A new `start` is accepted from t+1 onward.
- `busy` follows `S` combinationally with no added delay.

## Configuration
- `CTRL_SINGLE_STEP_EN` defined:
  - Adds input `step` (1 bit).
  - Every transition other than reset and illegal-state recovery additionally requires `step`=1 in that cycle. Otherwise the state holds, exactly as with `hold`.
  - `hold` still has priority over `step`.
- `CTRL_SINGLE_STEP_EN` undefined: no `step` port; transitions occur as described in Operation.

## Structure
- Shared package/include `ctrl_defs` holds:
  - the state code constants: ST_IDLE, ST_B1…ST_B10, ST_DONE, ST_LOOP_A, ST_LOOP_B;
  - the state width (4).
- The downstream decoder uses the same `ctrl_defs` constants.
- One sub-module, `iter_counter`, covers the loop counter:
  - load with `n_iter`;
  - decrement enable;
  - zero flag;
  - hold.
- The FSM next-state logic and the state register stay in `control_sequencer`.

## Test plan
- Reset, then `start`=1 with `n_iter`=0 → `S` steps 0001…1010, reaches 1011 at t+11 and holds. `ack` → 0000 next cycle. `busy` is high exactly 10 cycles.
- `n_iter`=2 → path passes through 1110/1111 twice. DONE at t+35. `iter_left` reads 2→1→0 after each 1010.
- `hold` asserted for 3 cycles at 0101 → `S` and `iter_left` unchanged for those cycles. DONE is delayed by exactly 3 cycles.
- `start` pulsed mid-run at 0100, and again together with `ack` in DONE → both ignored; `S`=0000 after `ack`. A following `start` is accepted.
- `rst` asserted at 1111 with `iter_left`=1 → `S`=0000, `iter_left`=0, `err`=0 next cycle.
- Force `S`=1101 → next cycle `S`=0000 and `err`=1. `err` stays 1 through a full later run until `rst`.
